// File: rtl/image_mem_pkg.sv
// Shared types and constants for the image data ROM path.
// Word-index address/data types, ROM size, starvation limit, arbiter FSM.
package image_mem_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam int ROM_DEPTH  = 90001;
  localparam int STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } arb_state_e;

endpackage

// File: rtl/dmem_stream_addr_gen.sv
// Burst address and remaining-count tracker for the stream port.
// Ports: load/base/len latch a burst, step advances one beat, addr/last out.
module dmem_stream_addr_gen
  import image_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int ROM_DEPTH = image_mem_pkg::ROM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] WRAP =
    ADDR_W'(ROM_DEPTH - 1);

  logic [LEN_W-1:0] remain;

  assign last = (remain == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      addr   <= '0;
      remain <= '0;
    end else if (load) begin
      addr   <= base;
      remain <= len;
    end else if (step) begin
      // Last valid word wraps back to word 0.
      addr   <= (addr == WRAP) ? '0 : addr + 1'b1;
      remain <= remain - 1'b1;
    end
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Arbitrates the image ROM read port between CPU loads and stream bursts.
// Ports: cpu_* single-beat port, str_* burst port, rom_addr/rom_rd to ROM.
module dmem_access_arbiter
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ROM_DEPTH  = image_mem_pkg::ROM_DEPTH,
  parameter int LEN_W      = 16,
  parameter int STARVE_MAX = image_mem_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              str_start,
  input  logic [ADDR_W-1:0] str_base,
  input  logic [LEN_W-1:0]  str_len,
  input  logic              str_ready,
  output logic              str_busy,
  output logic              str_rvalid,
  output logic [DATA_W-1:0] str_rdata,
  output logic              str_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd
);

  import image_mem_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ROM_DEPTH);

  arb_state_e        state;
  logic [SW-1:0]     starve;
  logic              str_elig;
  logic              str_win;
  logic              cpu_win;
  logic              cpu_ok;
  logic              sg_load;
  logic [ADDR_W-1:0] sg_addr;
  logic              sg_last;

  assign sg_load  = !reset && (state == IDLE) && str_start;
  assign str_busy = (state != IDLE);
  assign cpu_gnt  = cpu_win;

  dmem_stream_addr_gen #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .ROM_DEPTH (ROM_DEPTH)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (sg_load),
    .base  (str_base),
    .len   (str_len),
    .step  (str_win),
    .addr  (sg_addr),
    .last  (sg_last)
  );

  // Grants are masked during reset so nothing is issued to the ROM.
  always_comb begin
    str_elig = !reset && (state == BURST) && str_ready;
    str_win  = str_elig && (!cpu_req || (starve == SMAX));
    cpu_win  = !reset && cpu_req && !str_win;
    cpu_ok   = (cpu_addr < LIMIT);
    rom_addr = '0;
    unique case (1'b1)
      str_win:           rom_addr = sg_addr;
      cpu_win && cpu_ok: rom_addr = cpu_addr;
      default:           rom_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve     <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      str_rvalid <= 1'b0;
      str_rdata  <= '0;
      str_done   <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_win;
      str_rvalid <= str_win;
      str_done   <= 1'b0;
      if (cpu_win)
        cpu_rdata <= cpu_ok ? rom_rd : '0;
      if (str_win)
        str_rdata <= rom_rd;
      // Count only cycles where the stream was ready but lost.
      if (str_elig && !str_win) begin
        if (starve != SMAX)
          starve <= starve + 1'b1;
      end else begin
        starve <= '0;
      end
      unique case (state)
        IDLE: begin
          if (str_start) begin
            if (str_len == '0) begin
              state    <= DONE;
              str_done <= 1'b1;
            end else begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          // done lines up with the final beat's rvalid
          if (str_win && sg_last) begin
            state    <= DONE;
            str_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a combinational ROM model.
// Each task drives one scenario and checks outputs inline.
module tb_dmem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        str_start;
  logic [31:0] str_base;
  logic [15:0] str_len;
  logic        str_ready;
  logic        str_busy;
  logic        str_rvalid;
  logic [31:0] str_rdata;
  logic        str_done;
  logic [31:0] rom_addr;
  logic [31:0] rom_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(
    input logic [31:0] a
  );
    return 32'hA5A5_0000 ^ a;
  endfunction

  assign rom_rd = rom_fn(rom_addr);

  dmem_access_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .str_start  (str_start),
    .str_base   (str_base),
    .str_len    (str_len),
    .str_ready  (str_ready),
    .str_busy   (str_busy),
    .str_rvalid (str_rvalid),
    .str_rdata  (str_rdata),
    .str_done   (str_done),
    .rom_addr   (rom_addr),
    .rom_rd     (rom_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_addr = 0;
    str_start = 0; str_base = 0;
    str_len = 0; str_ready = 0;
    tick();
    tick();
    cpu_req = 1; cpu_addr = 5;
    #1;
    tests++;
    if ({cpu_gnt, cpu_rvalid, str_busy,
         str_rvalid, str_done} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 0",
        {cpu_gnt, cpu_rvalid, str_busy,
         str_rvalid, str_done});
    end
    tests++;
    if ({cpu_rdata, str_rdata, rom_addr} !== 96'b0)
    begin
      fails++;
      $display("FAIL reset_data got %h %h %h want 0",
        cpu_rdata, str_rdata, rom_addr);
    end
    cpu_req = 0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_only();
    cpu_req = 1; cpu_addr = 5;
    #1;
    tests++;
    if (cpu_gnt !== 1'b1 || rom_addr !== 32'd5) begin
      fails++;
      $display("FAIL cpu_gnt got %b/%0d want 1/5",
        cpu_gnt, rom_addr);
    end
    tick();
    cpu_req = 0;
    #1;
    tests++;
    if (cpu_rvalid !== 1'b1 ||
        cpu_rdata !== 32'hA5A5_0005) begin
      fails++;
      $display("FAIL cpu_data got %b/%h want 1/a5a50005",
        cpu_rvalid, cpu_rdata);
    end
    tick();
    tests++;
    if (cpu_rvalid !== 1'b0 || str_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL cpu_pulse got %b%b want 00",
        cpu_rvalid, str_rvalid);
    end
  endtask

  task automatic run_burst(
    input logic [31:0] base,
    input logic [15:0] len,
    input logic [31:0] e0,
    input logic [31:0] e1,
    input logic [31:0] e2,
    input logic [31:0] e3,
    input string       nm
  );
    logic [31:0] exp [4];
    exp[0] = e0; exp[1] = e1;
    exp[2] = e2; exp[3] = e3;
    str_ready = 1;
    str_start = 1; str_base = base; str_len = len;
    tick();
    str_start = 0;
    for (int k = 0; k < int'(len); k++) begin
      #1;
      tests++;
      if (rom_addr !== exp[k] || cpu_gnt !== 1'b0) begin
        fails++;
        $display("FAIL %s_addr%0d got %0d want %0d",
          nm, k, rom_addr, exp[k]);
      end
      tick();
      tests++;
      if (str_rvalid !== 1'b1 ||
          str_rdata !== rom_fn(exp[k]) ||
          str_done !== (k == int'(len) - 1) ||
          str_busy !== 1'b1) begin
        fails++;
        $display("FAIL %s_beat%0d got %b %h %b want 1 %h %b",
          nm, k, str_rvalid, str_rdata, str_done,
          rom_fn(exp[k]), (k == int'(len) - 1));
      end
    end
    tick();
    tests++;
    if (str_busy !== 1'b0 || str_rvalid !== 1'b0 ||
        str_done !== 1'b0) begin
      fails++;
      $display("FAIL %s_end got %b%b%b want 000",
        nm, str_busy, str_rvalid, str_done);
    end
  endtask

  task automatic test_burst();
    run_burst(32'd10, 16'd3, 32'd10, 32'd11,
              32'd12, 32'd0, "burst");
  endtask

  task automatic test_wrap();
    run_burst(32'd89999, 16'd4, 32'd89999,
              32'd90000, 32'd0, 32'd1, "wrap");
  endtask

  task automatic test_contention();
    int n;
    bit dn;
    logic exp_s;
    logic [31:0] sa;
    sa = 32'd100;
    str_ready = 1;
    cpu_req = 1; cpu_addr = 7;
    str_start = 1; str_base = 100; str_len = 8;
    tick();
    str_start = 0;
    for (int i = 0; i < 20; i++) begin
      exp_s = ((i + 1) % 5 == 0);
      #1;
      tests++;
      if (cpu_gnt !== !exp_s ||
          rom_addr !== (exp_s ? sa : 32'd7)) begin
        fails++;
        $display("FAIL cont_gnt%0d got %b/%0d want %b/%0d",
          i, cpu_gnt, rom_addr, !exp_s,
          exp_s ? sa : 32'd7);
      end
      if (exp_s) sa = sa + 1;
      tick();
      tests++;
      if (str_rvalid !== exp_s ||
          cpu_rvalid !== !exp_s) begin
        fails++;
        $display("FAIL cont_rv%0d got %b%b want %b%b",
          i, str_rvalid, cpu_rvalid, exp_s, !exp_s);
      end
    end
    cpu_req = 0;
    n = 0; dn = 0;
    for (int c = 0; c < 20 && !dn; c++) begin
      tick();
      if (str_rvalid) n++;
      if (str_done) dn = 1;
    end
    tests++;
    if (n != 4 || !dn || str_rdata !== rom_fn(107))
    begin
      fails++;
      $display("FAIL cont_drain got %0d %b %h want 4 1 %h",
        n, dn, str_rdata, rom_fn(107));
    end
    tick();
  endtask

  task automatic test_zero_len();
    str_ready = 1;
    str_start = 1; str_base = 50; str_len = 0;
    #1;
    tests++;
    if (rom_addr !== 32'd0) begin
      fails++;
      $display("FAIL zlen_addr got %0d want 0", rom_addr);
    end
    tick();
    str_start = 0;
    tests++;
    if (str_done !== 1'b1 || str_rvalid !== 1'b0 ||
        str_busy !== 1'b1) begin
      fails++;
      $display("FAIL zlen_done got %b%b%b want 101",
        str_done, str_rvalid, str_busy);
    end
    tick();
    tests++;
    if (str_done !== 1'b0 || str_busy !== 1'b0 ||
        str_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL zlen_end got %b%b%b want 000",
        str_done, str_busy, str_rvalid);
    end
  endtask

  task automatic test_cpu_oor();
    cpu_req = 1; cpu_addr = 32'd90000;
    tick();
    cpu_req = 1; cpu_addr = 32'd90001;
    tests++;
    if (cpu_rvalid !== 1'b1 ||
        cpu_rdata !== rom_fn(90000)) begin
      fails++;
      $display("FAIL cpu_last got %b/%h want 1/%h",
        cpu_rvalid, cpu_rdata, rom_fn(90000));
    end
    #1;
    tests++;
    if (cpu_gnt !== 1'b1 || rom_addr !== 32'd0) begin
      fails++;
      $display("FAIL oor_gnt got %b/%0d want 1/0",
        cpu_gnt, rom_addr);
    end
    tick();
    cpu_req = 0;
    tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd0)
    begin
      fails++;
      $display("FAIL oor_data got %b/%h want 1/0",
        cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_backpressure();
    str_ready = 1; cpu_req = 0;
    str_start = 1; str_base = 200; str_len = 4;
    tick();
    str_start = 0;
    #1;
    tests++;
    if (rom_addr !== 32'd200) begin
      fails++;
      $display("FAIL bp_a0 got %0d want 200", rom_addr);
    end
    tick();
    str_ready = 0; cpu_req = 1; cpu_addr = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (cpu_gnt !== 1'b1 || rom_addr !== 32'd3) begin
        fails++;
        $display("FAIL bp_stall%0d got %b/%0d want 1/3",
          i, cpu_gnt, rom_addr);
      end
      tick();
      tests++;
      if (str_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL bp_rv%0d got %b want 0",
          i, str_rvalid);
      end
    end
    str_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (cpu_gnt !== 1'b1) begin
        fails++;
        $display("FAIL bp_starve%0d got %b want 1",
          i, cpu_gnt);
      end
      tick();
    end
    #1;
    tests++;
    if (cpu_gnt !== 1'b0 || rom_addr !== 32'd201) begin
      fails++;
      $display("FAIL bp_resume got %b/%0d want 0/201",
        cpu_gnt, rom_addr);
    end
    tick();
    cpu_req = 0;
    for (int k = 202; k < 204; k++) begin
      #1;
      tests++;
      if (rom_addr !== 32'(k)) begin
        fails++;
        $display("FAIL bp_addr got %0d want %0d",
          rom_addr, k);
      end
      tick();
    end
    tests++;
    if (str_rvalid !== 1'b1 || str_done !== 1'b1 ||
        str_rdata !== rom_fn(203)) begin
      fails++;
      $display("FAIL bp_last got %b%b %h want 11 %h",
        str_rvalid, str_done, str_rdata, rom_fn(203));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    str_ready = 1; cpu_req = 0;
    str_start = 1; str_base = 300; str_len = 5;
    tick();
    str_start = 0;
    tick();
    tick();
    reset = 1;
    #1;
    tests++;
    if (rom_addr !== 32'd0) begin
      fails++;
      $display("FAIL rst_addr got %0d want 0", rom_addr);
    end
    tick();
    reset = 0;
    tests++;
    if ({str_busy, str_rvalid, str_done,
         cpu_rvalid} !== 4'b0 ||
        str_rdata !== 32'd0 || cpu_rdata !== 32'd0)
    begin
      fails++;
      $display("FAIL rst_out got %b %h %h want 0",
        {str_busy, str_rvalid, str_done, cpu_rvalid},
        str_rdata, cpu_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (str_done !== 1'b0 || str_rvalid !== 1'b0) begin
        fails++;
        $display("FAIL rst_quiet%0d got %b%b want 00",
          i, str_done, str_rvalid);
      end
    end
    str_start = 1; str_base = 20; str_len = 1;
    tick();
    str_start = 0;
    #1;
    tests++;
    if (rom_addr !== 32'd20) begin
      fails++;
      $display("FAIL rst_new got %0d want 20", rom_addr);
    end
    tick();
    tests++;
    if (str_rvalid !== 1'b1 || str_done !== 1'b1 ||
        str_rdata !== rom_fn(20)) begin
      fails++;
      $display("FAIL rst_newbeat got %b%b %h want 11 %h",
        str_rvalid, str_done, str_rdata, rom_fn(20));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_burst();
    test_contention();
    test_zero_len();
    test_wrap();
    test_cpu_oor();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
      tests, fails);
    $finish;
  end

endmodule
